// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX/MEM hazard inputs toward the sequencer, pipeline enables,
// bubbles and counters back. The master side drives the hazard inputs; the slave side is the sequencer.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IFIDRegRs;
  logic [4:0]       IFIDRegRt;
  logic             IFIDUsesRt;
  logic [4:0]       IDEXRegRt;
  logic             IDEXMemRead;
  logic             branchTaken;
  logic             memReq;
  logic             memReady;
  logic             PCWr;
  logic             IFIDWr;
  logic             IDEXWr;
  logic             EXMEMWr;
  logic             IFIDFlush;
  logic             IDEXBubble;
  logic             MEMWBBubble;
  logic             memTimeout;
  logic [CNT_W-1:0] stallCycles;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output IFIDRegRs, IFIDRegRt, IFIDUsesRt, IDEXRegRt, IDEXMemRead,
           branchTaken, memReq, memReady,
    input  PCWr, IFIDWr, IDEXWr, EXMEMWr, IFIDFlush, IDEXBubble, MEMWBBubble,
           memTimeout, stallCycles, flushCount
  );

  modport slave (
    input  IFIDRegRs, IFIDRegRt, IFIDUsesRt, IDEXRegRt, IDEXMemRead,
           branchTaken, memReq, memReady,
    output PCWr, IFIDWr, IDEXWr, EXMEMWr, IFIDFlush, IDEXBubble, MEMWBBubble,
           memTimeout, stallCycles, flushCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: controls are combinational in the detection cycle,
// and the counters and timeout are registered. A memory wait freezes the whole pipe, with a watchdog bounding the wait.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WCW = $clog2(MAX_WAIT) + 1;

  typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

  state_t           state, state_nxt;
  logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic mem_stall, load_use, freeze, br_honoured;
  logic pc_wr, ifid_wr, idex_wr, exmem_wr, ifid_flush, idex_bubble, memwb_bubble;

  assign mem_stall = hz.memReq & ~hz.memReady;
  assign load_use  = hz.IDEXMemRead & (hz.IDEXRegRt != 5'd0) &
                     ((hz.IDEXRegRt == hz.IFIDRegRs) |
                      (hz.IFIDUsesRt & (hz.IDEXRegRt == hz.IFIDRegRt)));
  assign freeze      = (state == ERR) | mem_stall;
  assign br_honoured = ~rst & ~freeze & hz.branchTaken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ERR) timeout_q <= 1'b1;
      if (!pc_wr && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + 1'b1;
      if (br_honoured && flush_q != {CNT_W{1'b1}}) flush_q <= flush_q + 1'b1;
    end
  end

  // A released or aborted access returns to RUN in the same cycle the pipe advances.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = MEMWAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      MEMWAIT: begin
        if (!mem_stall) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pc_wr        = 1'b1;
    ifid_wr      = 1'b1;
    idex_wr      = 1'b1;
    exmem_wr     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      pc_wr        = 1'b0;
      ifid_wr      = 1'b0;
      idex_wr      = 1'b0;
      exmem_wr     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_wr        = 1'b0;
      ifid_wr      = 1'b0;
      idex_wr      = 1'b0;
      exmem_wr     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (hz.branchTaken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_wr       = 1'b0;
      ifid_wr     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign hz.PCWr        = pc_wr;
  assign hz.IFIDWr      = ifid_wr;
  assign hz.IDEXWr      = idex_wr;
  assign hz.EXMEMWr     = exmem_wr;
  assign hz.IFIDFlush   = ifid_flush;
  assign hz.IDEXBubble  = idex_bubble;
  assign hz.MEMWBBubble = memwb_bubble;
  assign hz.memTimeout  = timeout_q;
  assign hz.stallCycles = stall_q;
  assign hz.flushCount  = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MAX_WAIT=4, CNT_W=4: hazards, priority, memory wait,
// timeout/ERR with counter saturation, and reset recovery.
module tb_pipe_hazard_ctrl;
  localparam int MW = 4;
  localparam int CW = 4;

  // Control order: {PCWr, IFIDWr, IDEXWr, EXMEMWr, IFIDFlush, IDEXBubble, MEMWBBubble}
  localparam logic [6:0] C_RUN = 7'b1111000;
  localparam logic [6:0] C_LU  = 7'b0011010;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_RST = 7'b0000111;

  typedef struct packed {
    logic [6:0]    ctrl;
    logic          to;
    logic [CW-1:0] st;
    logic [CW-1:0] fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) hz ();
  pipe_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .hz(hz));

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] m_stall  = '0;
  logic [CW-1:0] m_flush  = '0;

  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                      input logic [4:0] exrt, input logic mrd, input logic br, input logic mreq,
                      input logic mrdy, input logic [6:0] ctrl, input logic to, input bit chk_cnt,
                      input string tag);
    exp_t       e;
    logic [6:0] obs;
    rst            = r;
    hz.IFIDRegRs   = rs;
    hz.IFIDRegRt   = rt;
    hz.IFIDUsesRt  = uses;
    hz.IDEXRegRt   = exrt;
    hz.IDEXMemRead = mrd;
    hz.branchTaken = br;
    hz.memReq      = mreq;
    hz.memReady    = mrdy;
    sb.push_back('{ctrl: ctrl, to: to, st: m_stall, fl: m_flush});
    #3;
    e   = sb.pop_front();
    obs = {hz.PCWr, hz.IFIDWr, hz.IDEXWr, hz.EXMEMWr, hz.IFIDFlush, hz.IDEXBubble, hz.MEMWBBubble};
    checks++;
    assert (obs === e.ctrl) else begin
      failures++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, e.ctrl);
    end
    if (chk_cnt) begin
      checks++;
      assert (hz.memTimeout === e.to) else begin
        failures++;
        $error("FAIL %s memTimeout observed=%b expected=%b", tag, hz.memTimeout, e.to);
      end
      checks++;
      assert (hz.stallCycles === e.st) else begin
        failures++;
        $error("FAIL %s stallCycles observed=%0d expected=%0d", tag, hz.stallCycles, e.st);
      end
      checks++;
      assert (hz.flushCount === e.fl) else begin
        failures++;
        $error("FAIL %s flushCount observed=%0d expected=%0d", tag, hz.flushCount, e.fl);
      end
    end
    if (r) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!ctrl[6] && m_stall != {CW{1'b1}}) m_stall = m_stall + 1'b1;
      if (ctrl[2] && m_flush != {CW{1'b1}}) m_flush = m_flush + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    //   rst rs    rt    use exrt  mrd br  req rdy  ctrl   to  chk
    step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_RST, 0, 0, "reset_out");
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_RUN, 0, 1, "idle");
    step(0, 5'd1, 5'd5, 1, 5'd1, 1, 0, 0, 0, C_LU,  0, 1, "load_use_rs");
    step(0, 5'd1, 5'd5, 1, 5'd1, 0, 0, 0, 0, C_RUN, 0, 1, "load_use_done");
    step(0, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, C_RUN, 0, 1, "reg0_no_stall");
    step(0, 5'd1, 5'd5, 0, 5'd5, 1, 0, 0, 0, C_RUN, 0, 1, "rt_unused");
    step(0, 5'd1, 5'd5, 1, 5'd5, 1, 0, 0, 0, C_LU,  0, 1, "rt_used");
    step(0, 5'd1, 5'd5, 1, 5'd1, 1, 1, 0, 0, C_BR,  0, 1, "branch_over_lu");
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_RUN, 0, 1, "after_branch");
    for (int i = 0; i < 3; i++)
      step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, C_FRZ, 0, 1, "mem_freeze");
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, C_RUN, 0, 1, "mem_release");
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, C_FRZ, 0, 1, "abort_freeze");
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_RUN, 0, 1, "abort_release");
    for (int i = 0; i < MW; i++)
      step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, C_FRZ, 0, 1, "wait_to_limit");
    for (int i = 0; i < 10; i++)
      step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, C_FRZ, 1, 1, "err_hold_sat");
    step(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_RST, 1, 1, "reset_in_err");
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_RUN, 0, 1, "post_reset");
    for (int i = 0; i < 3; i++)
      step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, C_FRZ, 0, 1, "post_rst_wait");
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1, C_BR,  0, 1, "release_branch");
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, C_RUN, 0, 1, "final_counts");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
